// File: rtl/special_cases_maf_pipe_if.sv
// Handshake and operand/result bundle between the MAF exception resolver and its neighbours.
interface special_cases_maf_pipe_if #(
  parameter int size_exception_field = 2,
  parameter int CNT_W                = 16
);
  logic                            in_valid;
  logic                            in_ready;
  logic [size_exception_field-1:0] sp_case_a_number;
  logic [size_exception_field-1:0] sp_case_b_number;
  logic [size_exception_field-1:0] sp_case_c_number;
  logic                            sign_a;
  logic                            sign_b;
  logic                            sign_c;
  logic                            op_neg_prod;
  logic                            op_sub;
  logic                            clr_sticky;
  logic                            out_valid;
  logic                            out_ready;
  logic [size_exception_field-1:0] sp_case_result_o;
  logic                            sign_result_o;
  logic                            invalid_o;
  logic                            invalid_sticky_o;
  logic [CNT_W-1:0]                special_cnt_o;

  modport master (
    output in_valid, sp_case_a_number, sp_case_b_number, sp_case_c_number,
           sign_a, sign_b, sign_c, op_neg_prod, op_sub, clr_sticky, out_ready,
    input  in_ready, out_valid, sp_case_result_o, sign_result_o, invalid_o,
           invalid_sticky_o, special_cnt_o
  );

  modport slave (
    input  in_valid, sp_case_a_number, sp_case_b_number, sp_case_c_number,
           sign_a, sign_b, sign_c, op_neg_prod, op_sub, clr_sticky, out_ready,
    output in_ready, out_valid, sp_case_result_o, sign_result_o, invalid_o,
           invalid_sticky_o, special_cnt_o
  );
endinterface

// File: rtl/special_cases_maf_pipe.sv
// Pipelined exception-class resolver for (+/-a*b) +/- c, with invalid flagging,
// a sticky invalid flag and a saturating count of non-normal results.
module special_cases_maf_pipe #(
  parameter int size_exception_field = 2,
  parameter int zero                 = 0,
  parameter int normal_number        = 1,
  parameter int infinity             = 2,
  parameter int NaN                  = 3,
  parameter int PIPE_STAGES          = 2,
  parameter int CNT_W                = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  special_cases_maf_pipe_if.slave bus
);
  localparam int W    = size_exception_field;
  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [W-1:0] C_ZERO = W'(zero);
  localparam logic [W-1:0] C_NORM = W'(normal_number);
  localparam logic [W-1:0] C_INF  = W'(infinity);
  localparam logic [W-1:0] C_NAN  = W'(NaN);

  typedef struct packed {
    logic [W-1:0] cls;
    logic         sgn;
    logic         inv;
  } res_t;

  function automatic logic is_legal(input logic [W-1:0] x);
    return (x == C_ZERO) || (x == C_NORM) || (x == C_INF) || (x == C_NAN);
  endfunction

  function automatic res_t resolve(input logic [W-1:0] a, b, c,
                                   input logic sa, sb, sc, neg, sub);
    res_t         r;
    logic         ps;
    logic         cs;
    logic [W-1:0] pc;
    logic         pinv;
    r    = '{cls: C_ZERO, sgn: 1'b0, inv: 1'b0};
    ps   = sa ^ sb ^ neg;
    cs   = sc ^ sub;
    pinv = 1'b0;
    // Product class; 0*inf is the only product that raises invalid by itself.
    if ((a == C_NAN) || (b == C_NAN)) begin
      pc = C_NAN;
    end else if (((a == C_ZERO) && (b == C_INF)) || ((a == C_INF) && (b == C_ZERO))) begin
      pc   = C_NAN;
      pinv = 1'b1;
    end else if ((a == C_INF) || (b == C_INF)) begin
      pc = C_INF;
    end else if ((a == C_ZERO) || (b == C_ZERO)) begin
      pc = C_ZERO;
    end else begin
      pc = C_NORM;
    end

    if (!is_legal(a) || !is_legal(b) || !is_legal(c)) begin
      r = '{cls: C_ZERO, sgn: 1'b0, inv: 1'b0};
    end else if ((pc == C_NAN) || (c == C_NAN)) begin
      r = '{cls: C_NAN, sgn: 1'b0, inv: pinv};
    end else if ((pc == C_INF) && (c == C_INF) && (ps != cs)) begin
      r = '{cls: C_NAN, sgn: 1'b0, inv: 1'b1};
    end else if (pc == C_INF) begin
      r = '{cls: C_INF, sgn: ps, inv: 1'b0};
    end else if (c == C_INF) begin
      r = '{cls: C_INF, sgn: cs, inv: 1'b0};
    end else if ((pc == C_ZERO) && (c == C_ZERO)) begin
      // Exact zero sum keeps the common sign, otherwise rounds to +0.
      r = '{cls: C_ZERO, sgn: ps & cs, inv: 1'b0};
    end else begin
      r = '{cls: C_NORM, sgn: 1'b0, inv: 1'b0};
    end
    return r;
  endfunction

  logic             en;
  logic             hs;
  res_t             res_d;
  logic             vld_q [PIPE_STAGES];
  res_t             res_q [PIPE_STAGES];
  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign en = !vld_q[LAST] || bus.out_ready;
  assign hs = vld_q[LAST] && bus.out_ready;

  always_comb begin
    res_d = resolve(bus.sp_case_a_number, bus.sp_case_b_number, bus.sp_case_c_number,
                    bus.sign_a, bus.sign_b, bus.sign_c, bus.op_neg_prod, bus.op_sub);
  end

  // Stage 0 captures the resolved fields; later stages are pure delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        vld_q[i] <= 1'b0;
        res_q[i] <= '{cls: C_ZERO, sgn: 1'b0, inv: 1'b0};
      end
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      res_q[0] <= res_d;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (hs && res_q[LAST].inv) begin
      sticky_d = 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_d = 1'b0;
    end
    // Clear beats a coincident increment.
    if (bus.clr_sticky) begin
      cnt_d = '0;
    end else if (hs && (res_q[LAST].cls != C_NORM) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready         = en;
  assign bus.out_valid        = vld_q[LAST];
  assign bus.sp_case_result_o = res_q[LAST].cls;
  assign bus.sign_result_o    = res_q[LAST].sgn;
  assign bus.invalid_o        = res_q[LAST].inv;
  assign bus.invalid_sticky_o = sticky_q;
  assign bus.special_cnt_o    = cnt_q;
endmodule
